// File: rtl/ex_div.sv
// ex_div: multi-cycle 32-bit radix-2 restoring divider for the execute stage.
// Produces {remainder, quotient}; signed mode divides magnitudes and fixes the
// signs at the end. Results are held while start_i stays high.
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        sgn_a;
  logic        sgn_b;
  logic        sgn_mode;

  logic [32:0] rem_sh;
  logic [32:0] rem_sub;
  logic        ge;
  logic [31:0] rem_nx;
  logic        accept;
  logic        iterate;

  // Magnitude of an operand; only signed operands with bit 31 set are negated.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs_if(input logic signed [31:0] v, input logic en);
    return (en && v[31]) ? -v : v;
  endfunction

  // Two's-complement negation used for the final sign correction.
  function automatic logic [31:0] neg_if(input logic signed [31:0] v, input logic en);
    return en ? -v : v;
  endfunction

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  always_comb begin
    rem_sh  = {rem, quo[31]};
    rem_sub = rem_sh - {1'b0, dvs};
    ge      = (rem_sh >= {1'b0, dvs});
    rem_nx  = ge ? rem_sub[31:0] : rem_sh[31:0];
    accept  = (state == FREE) && start_i && !annul_i && (opdata2_i != 32'd0);
    iterate = (state == ON) && !annul_i && (cnt != 6'd32);
  end

  // Datapath registers: operands latched on acceptance, then shifted each step.
  always_ff @(posedge clk) begin
    if (accept) begin
      quo      <= abs_if(opdata1_i, signed_div_i);
      dvs      <= abs_if(opdata2_i, signed_div_i);
      rem      <= 32'd0;
      sgn_a    <= opdata1_i[31];
      sgn_b    <= opdata2_i[31];
      sgn_mode <= signed_div_i;
    end else if (iterate) begin
      quo <= {quo[30:0], ge};
      rem <= rem_nx;
    end
  end

  // Control FSM with registered outputs; annul wins over start and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          result_o <= 64'd0;
          ready_o  <= 1'b0;
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state <= BY_ZERO;
            end else begin
              state <= ON;
              cnt   <= 6'd0;
            end
          end
        end
        BY_ZERO: begin
          if (annul_i) begin
            state    <= FREE;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end else begin
            state    <= END;
            result_o <= 64'd0;
            ready_o  <= 1'b1;
          end
        end
        ON: begin
          if (annul_i) begin
            state    <= FREE;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end else if (cnt == 6'd32) begin
            result_o <= {neg_if(rem, sgn_mode && sgn_a),
                         neg_if(quo, sgn_mode && (sgn_a ^ sgn_b))};
            ready_o  <= 1'b1;
            state    <= END;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        END: begin
          if (annul_i || !start_i) begin
            state    <= FREE;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end
        end
        default: begin
          state    <= FREE;
          result_o <= 64'd0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle 32-bit integer divider attached to the execute stage. EX raises a start request with two operands and a signedness flag. It holds the request until `ready_o` pulses high and then takes a 64-bit result: remainder in the upper word, quotient in the lower word. The unit is radix-2 restoring, one quotient bit per cycle. EX stalls the pipeline while the divide is in flight.

## Interface
- No parameters; datapath is fixed at 32 bits.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- `opdata1_i`  in  32  dividend; sampled with start
- `opdata2_i`  in  32  divisor; sampled with start
- `start_i`  in  1  request; held high by EX until it has consumed the result
- `annul_i`  in  1  abort the divide in flight (pipeline flush)
- `result_o`  out  64  {remainder, quotient}; valid only while `ready_o`=1, else 0
- `ready_o`  out  1  result valid

## Operation
- States: FREE, BY_ZERO, ON, END. Reset value: state=FREE, `result_o`=0, `ready_o`=0, counter=0.
- FREE
  - If `start_i`=1, `annul_i`=0 and `opdata2_i`=0: go to BY_ZERO.
  - If `start_i`=1, `annul_i`=0 and `opdata2_i`≠0: go to ON.
    - Latch |dividend| and |divisor|. Absolute value is taken only when `signed_div_i`=1 and the operand bit 31 = 1.
    - Latch the two operand sign bits and `signed_div_i`; clear the remainder accumulator and counter.
  - Otherwise stay in FREE.
- BY_ZERO: unconditionally go to END with the result forced to 64'h0.
- ON, one iteration per cycle while counter < 32:
  - remainder' = {remainder[31:0], quotient[31]}; quotient shifts left.
  - If remainder' ≥ divisor (33-bit unsigned compare): subtract the divisor and set quotient[0]=1.
  - Counter increments.
- ON with counter = 32: apply the sign correction, register it into `result_o`, set `ready_o`=1, go to END.
- Sign correction (signed only):
  - Quotient is negated (two's complement) when dividend sign XOR divisor sign = 1.
  - Remainder is negated when the dividend sign = 1.
  - Unsigned mode applies no correction.
- Overflow case 0x80000000 / 0xFFFFFFFF, signed: quotient 0x80000000, remainder 0. No trap.
- END
  - Hold `result_o` and `ready_o`=1 while `start_i`=1.
  - When `start_i`=0: go to FREE with `result_o`=0 and `ready_o`=0.
- `annul_i`=1 in ON, BY_ZERO or END: go to FREE next cycle; `ready_o`=0, `result_o`=0. `annul_i` has priority over start and completion.
- `rst` in any state overrides everything; reset values apply on the next edge.
- Operand inputs are ignored outside the FREE→ON/BY_ZERO sampling edge. EX may change them freely during the divide.

## Timing
- Normal divide, with `start_i` first high in cycle 0:
  - Cycles 1–32: ON, iterating.
  - Cycle 33: ON with counter = 32, finalisation.
  - `ready_o`=1 from cycle 34.
  - Latency is 34 cycles from the start cycle to the first ready cycle.
- Divide by zero: BY_ZERO in cycle 1; `ready_o`=1 with result 0 from cycle 2.
- After EX drops `start_i` in cycle N, `ready_o` falls in cycle N+1. A new start is accepted in cycle N+1 at the earliest, because FREE must be re-entered first.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Unsigned 100 / 7 -> `ready_o` rises exactly 34 cycles after start; `result_o`=0x00000002_0000000E.
- Signed -7 / 2 (0xFFFFFFF9, 0x2) -> `result_o`=0xFFFFFFFF_FFFFFFFD. The same operands in unsigned mode -> quotient 0x7FFFFFFC, remainder 0x00000001.
- Divisor 0, signed and unsigned -> `ready_o` in cycle 2; `result_o`=0.
- `annul_i` pulsed in cycle 10 of a divide -> FREE in cycle 11; `ready_o` never rises. Then a back-to-back new start (0xFFFFFFFF / 0x10, unsigned) -> quotient 0x0FFFFFFF, remainder 0xF.
- Hold `start_i` 5 cycles past ready -> result stable with `ready_o`=1. Drop start -> `ready_o` and `result_o` return to 0 next cycle.
- Signed 0x80000000 / 0xFFFFFFFF -> `result_o`=0x00000000_80000000. Assert `rst` mid-divide (cycle 20) -> all outputs 0, state FREE next cycle.
